// File: rtl/mul_issue_if.sv
// Issue and writeback handshake bundle for the multiply issue/capture stage.
interface mul_issue_if #(
   parameter int unsigned N    = 16,
   parameter int unsigned RD_W = 4
);
   logic            in_valid;
   logic            in_ready;
   logic [N-1:0]    in_rs1;
   logic [N-1:0]    in_rs2;
   logic [RD_W-1:0] in_rd_addr;
   logic            in_hi;
   logic            out_valid;
   logic            out_ready;
   logic [N-1:0]    out_data;
   logic [RD_W-1:0] out_rd_addr;

   modport master (
      output in_valid, in_rs1, in_rs2, in_rd_addr, in_hi, out_ready,
      input  in_ready, out_valid, out_data, out_rd_addr
   );

   modport slave (
      input  in_valid, in_rs1, in_rs2, in_rd_addr, in_hi, out_ready,
      output in_ready, out_valid, out_data, out_rd_addr
   );
endinterface

// File: rtl/mul_issue_ctrl.sv
// Multicycle issue/capture wrapper around a combinational multiplier array:
// holds operands for LAT cycles, then captures the selected product half.
module mul_issue_ctrl #(
   parameter int unsigned N    = 16,
   parameter int unsigned LAT  = 2,
   parameter int unsigned RD_W = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           flush,
   mul_issue_if.slave     io,
   output logic [N-1:0]   mul_rs1,
   output logic [N-1:0]   mul_rs2,
   input  logic [2*N-1:0] mul_rd,
   output logic           busy
);

   localparam int unsigned CNT_W = $clog2(LAT + 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              accept_c;
   logic              capture_c;
   logic              in_ready_c;
   logic [N-1:0]      rs1_q, rs2_q, data_q;
   logic [RD_W-1:0]   addr_q;
   logic              hi_q;

   // Next-state: flush overrides every transition and blocks acceptance.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      in_ready_c = 1'b0;
      capture_c  = 1'b0;
      unique case (state_q)
         IDLE: begin
            in_ready_c = !flush;
            if (io.in_valid && in_ready_c) begin
               state_d = CALC;
               cnt_d   = CNT_W'(LAT - 1);
            end
         end
         CALC: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               capture_c = 1'b1;
               state_d   = DONE;
            end
         end
         DONE: begin
            in_ready_c = io.out_ready && !flush;
            if (io.out_ready) begin
               if (io.in_valid) begin
                  state_d = CALC;
                  cnt_d   = CNT_W'(LAT - 1);
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (flush) begin
         state_d   = IDLE;
         capture_c = 1'b0;
      end
   end

   assign accept_c = io.in_valid && in_ready_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Operand/result holding registers; operands stay frozen until the next accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rs1_q  <= '0;
         rs2_q  <= '0;
         addr_q <= '0;
         hi_q   <= 1'b0;
         data_q <= '0;
      end else begin
         if (accept_c) begin
            rs1_q  <= io.in_rs1;
            rs2_q  <= io.in_rs2;
            addr_q <= io.in_rd_addr;
            hi_q   <= io.in_hi;
         end
         if (capture_c) begin
            data_q <= hi_q ? mul_rd[2*N-1:N] : mul_rd[N-1:0];
         end
      end
   end

   assign io.in_ready    = in_ready_c;
   assign io.out_valid   = (state_q == DONE);
   assign io.out_data    = data_q;
   assign io.out_rd_addr = addr_q;
   assign mul_rs1        = rs1_q;
   assign mul_rs2        = rs2_q;
   assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Randomized and directed bench for mul_issue_ctrl against a transaction-level model.
module tb_mul_issue_ctrl;
   localparam int unsigned N    = 16;
   localparam int unsigned LAT  = 2;
   localparam int unsigned RD_W = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;
   logic [N-1:0]   mul_rs1, mul_rs2;
   logic [2*N-1:0] mul_rd;
   logic           busy;

   always #5 clk = ~clk;

   mul_issue_if #(.N(N), .RD_W(RD_W)) io ();

   // Behavioural multiplier array
   assign mul_rd = 32'(mul_rs1) * 32'(mul_rs2);

   mul_issue_ctrl #(.N(N), .LAT(LAT), .RD_W(RD_W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (flush),
      .io      (io),
      .mul_rs1 (mul_rs1),
      .mul_rs2 (mul_rs2),
      .mul_rd  (mul_rd),
      .busy    (busy)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   // Reference: at most one op in flight, result due LAT edges after acceptance
   bit              m_busy = 1'b0;
   int              m_ready_at = 0;
   logic [N-1:0]    m_rs1 = '0, m_rs2 = '0, m_data = '0;
   logic [RD_W-1:0] m_addr = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic step(input bit iv, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [RD_W-1:0] rd, input bit hi, input bit ordy, input bit fl,
                       output bit acc, output bit dlv,
                       output logic [N-1:0] dat, output logic [RD_W-1:0] adr);
      bit exp_valid, exp_ready;
      logic [31:0] prod;
      @(negedge clk);
      io.in_valid   = iv;
      io.in_rs1     = a;
      io.in_rs2     = b;
      io.in_rd_addr = rd;
      io.in_hi      = hi;
      io.out_ready  = ordy;
      flush         = fl;
      #1;
      exp_valid = m_busy && (cyc >= m_ready_at);
      exp_ready = !fl && (!m_busy || (exp_valid && ordy));
      check("out_valid", 32'(io.out_valid), 32'(exp_valid));
      check("in_ready", 32'(io.in_ready), 32'(exp_ready));
      check("busy", 32'(busy), 32'(m_busy));
      if (exp_valid) begin
         check("out_data", 32'(io.out_data), 32'(m_data));
         check("out_rd_addr", 32'(io.out_rd_addr), 32'(m_addr));
      end else if (m_busy) begin
         check("mul_rs1_hold", 32'(mul_rs1), 32'(m_rs1));
         check("mul_rs2_hold", 32'(mul_rs2), 32'(m_rs2));
      end
      dat = io.out_data;
      adr = io.out_rd_addr;
      acc = iv && exp_ready;
      dlv = exp_valid && ordy && !fl;
      if (fl) begin
         m_busy = 1'b0;
      end else if (acc) begin
         prod       = 32'(a) * 32'(b);
         m_busy     = 1'b1;
         m_ready_at = cyc + 1 + int'(LAT);
         m_rs1      = a;
         m_rs2      = b;
         m_addr     = rd;
         m_data     = hi ? prod[31:16] : prod[15:0];
      end else if (dlv) begin
         m_busy = 1'b0;
      end
      @(posedge clk);
      cyc++;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      io.in_valid  = 1'b0;
      io.out_ready = 1'b0;
      flush        = 1'b0;
      rst_n        = 1'b0;
      #1;
      check("rst_out_valid", 32'(io.out_valid), 32'd0);
      check("rst_in_ready", 32'(io.in_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_out_data", 32'(io.out_data), 32'd0);
      check("rst_mul_rs1", 32'(mul_rs1), 32'd0);
      check("rst_mul_rs2", 32'(mul_rs2), 32'd0);
      m_busy = 1'b0;
      @(posedge clk);
      cyc++;
      #1;
      check("rst_hold_valid", 32'(io.out_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [RD_W-1:0] rd, input bit hi, output int t_acc);
      bit acc, dlv;
      logic [N-1:0] d;
      logic [RD_W-1:0] ad;
      acc = 1'b0;
      t_acc = -1;
      for (int i = 0; i < 20 && !acc; i++) begin
         step(1'b1, a, b, rd, hi, 1'b1, 1'b0, acc, dlv, d, ad);
      end
      if (acc) t_acc = cyc;
      else check("issue_timeout", 32'd0, 32'd1);
   endtask

   task automatic get_result(input string tag, input logic [N-1:0] exp_d,
                             input logic [RD_W-1:0] exp_a, output int t_dlv);
      bit acc, dlv;
      logic [N-1:0] d;
      logic [RD_W-1:0] ad;
      dlv = 1'b0;
      t_dlv = -1;
      for (int i = 0; i < 20 && !dlv; i++) begin
         t_dlv = cyc;
         step(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0, acc, dlv, d, ad);
      end
      if (dlv) begin
         check(tag, 32'(d), 32'(exp_d));
         check({tag, "_addr"}, 32'(ad), 32'(exp_a));
      end else begin
         check({tag, "_timeout"}, 32'd0, 32'd1);
      end
   endtask

   initial begin
      int t_a, t_d;
      bit acc, dlv, seen;
      logic [N-1:0] d;
      logic [RD_W-1:0] ad;
      logic [N-1:0] ops_a [3];
      logic [N-1:0] ops_b [3];
      logic [N-1:0] res [3];
      int res_t [3];
      int idx, nres;

      io.in_valid = 1'b0; io.in_rs1 = '0; io.in_rs2 = '0;
      io.in_rd_addr = '0; io.in_hi = 1'b0; io.out_ready = 1'b0;
      pulse_reset();

      // Basic op and its latency
      issue(16'd3, 16'd5, 4'd7, 1'b0, t_a);
      get_result("res_3x5", 16'h000F, 4'd7, t_d);
      check("latency", 32'(t_d - t_a), 32'(LAT));

      // Full-width product halves
      issue(16'hFFFF, 16'hFFFF, 4'd1, 1'b1, t_a);
      get_result("res_ffff_hi", 16'hFFFE, 4'd1, t_d);
      issue(16'hFFFF, 16'hFFFF, 4'd2, 1'b0, t_a);
      get_result("res_ffff_lo", 16'h0001, 4'd2, t_d);

      // Writeback backpressure while upstream keeps offering a new op
      issue(16'h1111, 16'h2222, 4'd3, 1'b0, t_a);
      for (int i = 0; i < LAT + 5; i++)
         step(1'b1, 16'd9, 16'd9, 4'd4, 1'b0, 1'b0, 1'b0, acc, dlv, d, ad);
      get_result("res_stall", 16'h8642, 4'd3, t_d);

      // Back-to-back stream
      ops_a[0] = 16'd2; ops_b[0] = 16'd3;
      ops_a[1] = 16'd4; ops_b[1] = 16'd4;
      ops_a[2] = 16'd7; ops_b[2] = 16'd9;
      idx = 0; nres = 0;
      for (int i = 0; i < 30 && nres < 3; i++) begin
         res_t[nres] = cyc;
         if (idx < 3)
            step(1'b1, ops_a[idx], ops_b[idx], RD_W'(idx), 1'b0, 1'b1, 1'b0, acc, dlv, d, ad);
         else
            step(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0, acc, dlv, d, ad);
         if (dlv) begin res[nres] = d; nres++; end
         if (acc) idx++;
      end
      check("b2b_count", 32'(nres), 32'd3);
      if (nres == 3) begin
         check("b2b_res0", 32'(res[0]), 32'd6);
         check("b2b_res1", 32'(res[1]), 32'd16);
         check("b2b_res2", 32'(res[2]), 32'd63);
         check("b2b_gap01", 32'(res_t[1] - res_t[0]), 32'(LAT + 1));
         check("b2b_gap12", 32'(res_t[2] - res_t[1]), 32'(LAT + 1));
      end

      // Flush in the first CALC cycle with a competing op offered
      issue(16'd10, 16'd10, 4'd5, 1'b0, t_a);
      step(1'b1, 16'd7, 16'd7, 4'd6, 1'b0, 1'b1, 1'b1, acc, dlv, d, ad);
      check("flush_accept", 32'(acc), 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0, acc, dlv, d, ad);
         if (dlv) seen = 1'b1;
      end
      check("flush_no_result", 32'(seen), 32'd0);

      // Reset mid-CALC, then a fresh op
      issue(16'h5555, 16'd3, 4'd8, 1'b1, t_a);
      pulse_reset();
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0, acc, dlv, d, ad);
         if (dlv) seen = 1'b1;
      end
      check("rst_no_result", 32'(seen), 32'd0);
      issue(16'h1234, 16'h0010, 4'd9, 1'b0, t_a);
      get_result("res_after_rst", 16'h2340, 4'd9, t_d);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         logic [N-1:0] ra, rb;
         ra = ($urandom_range(0, 7) == 0) ? 16'hFFFF : N'($urandom);
         rb = ($urandom_range(0, 7) == 0) ? 16'hFFFF : N'($urandom);
         step(bit'($urandom_range(0, 1)), ra, rb, RD_W'($urandom), bit'($urandom_range(0, 1)),
              $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, acc, dlv, d, ad);
      end
      for (int i = 0; i < 6; i++)
         step(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0, acc, dlv, d, ad);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
